// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: feeder FSM states and default sizing.
// BAUD_DIV is the serializer divisor the default TIMEOUT is sized against.
package uart_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_START = 2'd2,
      S_BUSY  = 2'd3
   } tx_state_t;

   localparam int BAUD_DIV    = 5207;
   localparam int DEF_DEPTH   = 16;
   localparam int DEF_TIMEOUT = 16383;

endpackage

// File: rtl/sync_fifo.sv
// Circular buffer with registered count/full/empty; writes to a full FIFO and pops of an empty one are ignored.
// rd_data shows the head entry combinationally; a simultaneous push and pop leaves count unchanged.
module sync_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int W      = 8
) (
   input  logic              sysclk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [W-1:0]      wr_data,
   input  logic              rd_en,
   output logic [W-1:0]      rd_data,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty
);

   logic [W-1:0]      mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              push;
   logic              pop;
   logic [ADDR_W:0]   count_nxt;

   assign push    = wr_en && !full;
   assign pop     = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (push && !pop)
         count_nxt = count + 1'b1;
      else if (pop && !push)
         count_nxt = count - 1'b1;
   end

   // Pointers are exactly ADDR_W bits, so wrap modulo DEPTH is free.
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         full  <= (count_nxt == (ADDR_W+1)'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

   always_ff @(posedge sysclk) begin
      if (push)
         mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and hands them one at a time to the UART serializer via tx_data/tx_start.
// First tx_start two cycles after a write into an idle feeder; the producer sees only `full`.
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH   = DEF_DEPTH,
   parameter int ADDR_W  = 4,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic              sysclk,
   input  logic              rst,
   input  logic [7:0]        wr_data,
   input  logic              wr_en,
   input  logic              clr_err,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic [7:0]        tx_data,
   output logic              tx_start,
   input  logic              tx_status,
   output logic              err_overflow,
   output logic              err_timeout
);

   localparam int TW = $clog2(TIMEOUT + 1);

   tx_state_t    state;
   tx_state_t    state_nxt;
   logic [TW-1:0] timer;
   logic [TW-1:0] timer_nxt;
   logic [7:0]   tx_data_nxt;
   logic         tx_start_nxt;
   logic         pop;
   logic         to_hit;
   logic [7:0]   rd_data;
   logic         st_meta;
   logic         st;

   // Status idles high, so the synchroniser resets to "ready".
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         st_meta <= 1'b1;
         st      <= 1'b1;
      end else begin
         st_meta <= tx_status;
         st      <= st_meta;
      end
   end

   sync_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .W      (8)
   ) u_fifo (
      .sysclk  (sysclk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (pop),
      .rd_data (rd_data),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   always_comb begin
      state_nxt    = state;
      tx_data_nxt  = tx_data;
      tx_start_nxt = tx_start;
      timer_nxt    = timer;
      pop          = 1'b0;
      to_hit       = 1'b0;
      case (state)
         S_IDLE: begin
            if (!empty) begin
               tx_data_nxt = rd_data;
               state_nxt   = S_LOAD;
            end
         end
         S_LOAD: begin
            tx_start_nxt = 1'b1;
            timer_nxt    = '0;
            state_nxt    = S_START;
         end
         S_START: begin
            // The head entry stays in the FIFO until the serializer has it or we give up.
            if (!st) begin
               pop          = 1'b1;
               tx_start_nxt = 1'b0;
               state_nxt    = S_BUSY;
            end else if (timer == TW'(TIMEOUT - 1)) begin
               pop          = 1'b1;
               tx_start_nxt = 1'b0;
               to_hit       = 1'b1;
               state_nxt    = S_IDLE;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         S_BUSY: begin
            if (st)
               state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         tx_data  <= 8'h00;
         tx_start <= 1'b0;
         timer    <= '0;
      end else begin
         state    <= state_nxt;
         tx_data  <= tx_data_nxt;
         tx_start <= tx_start_nxt;
         timer    <= timer_nxt;
      end
   end

   // A new error in the same cycle as clr_err wins.
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         err_overflow <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         if (wr_en && full)
            err_overflow <= 1'b1;
         else if (clr_err)
            err_overflow <= 1'b0;
         if (to_hit)
            err_timeout <= 1'b1;
         else if (clr_err)
            err_timeout <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: a serializer model pops the expected-byte queue on every accepted frame.
module tb_uart_tx_feeder;

   localparam int TO        = 20;
   localparam int FRAME_LEN = 6;
   localparam int M_NORMAL  = 0;
   localparam int M_STICK   = 1;
   localparam int M_DEAF    = 2;

   logic       sysclk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] wr_data = 8'h00;
   logic       wr_en = 1'b0;
   logic       clr_err = 1'b0;
   logic       tx_status = 1'b1;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       err_overflow;
   logic       err_timeout;

   int         tests = 0;
   int         fails = 0;
   int         frames = 0;
   int         mode = M_NORMAL;
   int         busy_cnt = 0;
   logic [7:0] sb[$];
   logic [7:0] latched = 8'h00;
   logic       prev_start = 1'b0;

   uart_tx_feeder #(
      .DEPTH   (16),
      .ADDR_W  (4),
      .TIMEOUT (TO)
   ) dut (
      .sysclk       (sysclk),
      .rst          (rst),
      .wr_data      (wr_data),
      .wr_en        (wr_en),
      .clr_err      (clr_err),
      .full         (full),
      .empty        (empty),
      .count        (count),
      .tx_data      (tx_data),
      .tx_start     (tx_start),
      .tx_status    (tx_status),
      .err_overflow (err_overflow),
      .err_timeout  (err_timeout)
   );

   always #5 sysclk = ~sysclk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge sysclk);
         #1;
      end
   endtask

   task automatic write_byte(input logic [7:0] b, input bit expect_tx);
      wr_en   = 1'b1;
      wr_data = b;
      if (expect_tx)
         sb.push_back(b);
      tick(1);
      wr_en = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (!(sb.size() == 0 && empty && !tx_start && tx_status && busy_cnt == 0) && k < 2000) begin
         tick(1);
         k++;
      end
      check("drain_done", 32'(k < 2000), 1);
      tick(6);
   endtask

   task automatic wait_status_low();
      int k;
      k = 0;
      while (tx_status && k < 40) begin
         tick(1);
         k++;
      end
      check("status_fell", 32'(tx_status), 0);
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      tick(1);
      clr_err = 1'b0;
   endtask

   // Serializer model: latches on tx_start while ready, then stays busy for FRAME_LEN cycles.
   initial begin
      forever begin
         @(posedge sysclk);
         #1;
         if (tx_start && !prev_start)
            check("start_when_ready", 32'(tx_status), 1);
         prev_start = tx_start;
         if (tx_status) begin
            if (tx_start && mode != M_DEAF) begin
               frames++;
               latched = tx_data;
               check("frame_expected", 32'(sb.size() > 0), 1);
               if (sb.size() > 0)
                  check("frame_data", 32'(tx_data), 32'(sb.pop_front()));
               tx_status = 1'b0;
               busy_cnt  = FRAME_LEN;
            end
         end else begin
            if (tx_start)
               check("data_stable", 32'(tx_data), 32'(latched));
            if (mode != M_STICK && busy_cnt > 0)
               busy_cnt--;
            if (busy_cnt == 0)
               tx_status = 1'b1;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      int f0;
      int n;

      tick(3);
      check("rst_empty", 32'(empty), 1);
      check("rst_full", 32'(full), 0);
      check("rst_count", 32'(count), 0);
      check("rst_tx_start", 32'(tx_start), 0);
      check("rst_tx_data", 32'(tx_data), 0);
      check("rst_err_ovf", 32'(err_overflow), 0);
      check("rst_err_to", 32'(err_timeout), 0);
      rst = 1'b0;
      tick(2);
      check("idle_tx_start", 32'(tx_start), 0);

      // Single byte: data at N+1, start at N+2, pop after acceptance
      write_byte(8'h41, 1'b1);
      check("t1_count", 32'(count), 1);
      tick(1);
      check("t1_data_n1", 32'(tx_data), 32'h41);
      check("t1_start_n1", 32'(tx_start), 0);
      tick(1);
      check("t1_start_n2", 32'(tx_start), 1);
      n = 0;
      while (tx_start && n < 20) begin
         tick(1);
         n++;
      end
      check("t1_start_dropped", 32'(tx_start), 0);
      check("t1_popped", 32'(count), 0);
      drain();

      // Burst of five
      f0 = frames;
      for (int i = 0; i < 5; i++)
         write_byte(8'h31 + 8'(i), 1'b1);
      drain();
      check("burst_frames", 32'(frames - f0), 5);

      // Overflow while the serializer is held busy
      mode = M_STICK;
      f0 = frames;
      write_byte(8'hA0, 1'b1);
      wait_status_low();
      tick(6);
      check("ovf_pilot_popped", 32'(count), 0);
      for (int i = 0; i < 17; i++)
         write_byte(8'h50 + 8'(i), i < 16);
      check("ovf_full", 32'(full), 1);
      check("ovf_count", 32'(count), 16);
      check("ovf_flag", 32'(err_overflow), 1);
      pulse_clr();
      check("ovf_cleared", 32'(err_overflow), 0);
      check("ovf_still_full", 32'(full), 1);
      mode = M_NORMAL;
      drain();
      check("ovf_frames", 32'(frames - f0), 17);

      // Timeout: a zero byte is offered for exactly TO cycles and dropped
      mode = M_DEAF;
      f0 = frames;
      write_byte(8'h00, 1'b0);
      write_byte(8'h77, 1'b1);
      n = 0;
      while (!tx_start && n < 50) begin
         tick(1);
         n++;
      end
      check("to_start_rose", 32'(tx_start), 1);
      n = 0;
      while (tx_start && n < 100) begin
         tick(1);
         n++;
      end
      check("to_start_len", 32'(n), TO);
      check("to_flag", 32'(err_timeout), 1);
      check("to_popped", 32'(count), 1);
      mode = M_NORMAL;
      drain();
      check("to_next_sent", 32'(frames - f0), 1);
      pulse_clr();
      check("to_cleared", 32'(err_timeout), 0);

      // Write lands on the same edge as the timeout pop, with count at 3
      mode = M_DEAF;
      f0 = frames;
      write_byte(8'hE0, 1'b0);
      write_byte(8'hE1, 1'b1);
      write_byte(8'hE2, 1'b1);
      check("sim_start_rise", 32'(tx_start), 1);
      check("sim_count_pre", 32'(count), 3);
      tick(TO - 1);
      write_byte(8'hE3, 1'b1);
      check("sim_popped", 32'(tx_start), 0);
      check("sim_count", 32'(count), 3);
      mode = M_NORMAL;
      drain();
      check("sim_frames", 32'(frames - f0), 3);
      pulse_clr();

      // Forty random bytes, enough to wrap the pointers several times
      f0 = frames;
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < 10; i++)
            write_byte(8'($urandom_range(0, 255)), 1'b1);
         drain();
      end
      check("wrap_frames", 32'(frames - f0), 40);

      // Reset while the serializer is busy with a frame
      mode = M_STICK;
      write_byte(8'hC3, 1'b1);
      write_byte(8'hC4, 1'b1);
      wait_status_low();
      tick(6);
      check("rstmid_count_pre", 32'(count), 1);
      rst = 1'b1;
      #1;
      check("rstmid_count", 32'(count), 0);
      check("rstmid_empty", 32'(empty), 1);
      check("rstmid_tx_start", 32'(tx_start), 0);
      sb.delete();
      f0 = frames;
      tick(2);
      rst = 1'b0;
      mode = M_NORMAL;
      tick(2);
      check("rstmid_tx_data", 32'(tx_data), 0);
      drain();
      check("rstmid_no_frames", 32'(frames - f0), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
Byte buffer and handshake sequencer sitting directly upstream of the UART serializer, which has inputs data[7:0] and start and a status output (1 = ready).
- Producer logic writes bytes at sysclk rate into a circular FIFO.
- The feeder presents one byte at a time on tx_data, pulses tx_start, and waits for the serializer to accept it and finish before offering the next.
- Converts a bursty producer into back-to-back 9600-baud frames without producer-side flow control beyond `full`.

Parameters:
DEPTH, 16, FIFO entries (power of two).
ADDR_W, 4, log2(DEPTH).
TIMEOUT, 16383, sysclk cycles allowed for the serializer to accept a byte; exceeds two baud periods at divisor 5207.

Ports:
sysclk  in  1  system clock, all logic on posedge.
rst  in  1  asynchronous, active-high reset.
wr_data  in  8  byte to enqueue.
wr_en  in  1  enqueue wr_data this cycle.
clr_err  in  1  clears sticky error flags.
full  out  1  FIFO holds DEPTH bytes.
empty  out  1  FIFO holds 0 bytes.
count  out  ADDR_W+1  current occupancy.
tx_data  out  8  byte presented to the serializer data input.
tx_start  out  1  start request to the serializer.
tx_status  in  1  serializer status; 1 = idle/ready, 0 = busy.
err_overflow  out  1  sticky: a write was attempted while full.
err_timeout  out  1  sticky: a byte was dropped after TIMEOUT.

Behaviour:
- Reset (async, rst=1):
  - Pointers 0, count 0, empty=1, full=0.
  - tx_data=8'h00, tx_start=0, both error flags 0, FSM=IDLE, sync flops=1.
- tx_status synchronisation:
  - tx_status comes from the pulse-clocked domain, so it passes through a 2-flop synchroniser before use. Call the synchronised value st.
- FIFO:
  - Write accepted when wr_en && !full.
  - wr_en && full: data dropped, err_overflow<=1.
  - Pop occurs only in ACCEPT (below).
  - Write and pop in the same cycle: both happen, count unchanged.
  - Pointers wrap modulo DEPTH.
  - count, full and empty are registered and consistent with the pointers every cycle.
- FSM states: IDLE, LOAD, START, BUSY.
  - IDLE: if !empty, tx_data<=mem[rd_ptr], go to LOAD.
  - LOAD: one setup cycle with tx_data stable; tx_start<=1, timer<=0, go to START.
  - START: tx_start held 1.
    - If st==0, the serializer has latched the byte: pop FIFO, tx_start<=0, go to BUSY.
    - Else if timer==TIMEOUT-1: pop (byte dropped), tx_start<=0, err_timeout<=1, go to IDLE.
    - Otherwise timer increments.
  - BUSY: wait for st==1 (serializer finished the stop bit), then go to IDLE.
    - tx_data may change only after leaving START, because the serializer freezes its latch while busy.
- Latency, empty FIFO with serializer idle:
  - Write at edge N → LOAD at N+1 → tx_start=1 at N+2.
- Zero bytes (8'h00) are sent like any other. If the serializer never accepts one, the timeout path drops it.
- clr_err clears both sticky flags. If a clear and a new error occur in the same cycle, the set wins.
- Reset mid-frame: the FIFO is emptied and tx_start drops immediately. The serializer finishes its current frame on its own.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encodings (IDLE/LOAD/START/BUSY).
  - BAUD_DIV=5207.
  - Default DEPTH and TIMEOUT.
- One sub-module, sync_fifo: parameterised DEPTH/width circular buffer with count/full/empty.
- The FSM, synchroniser and error logic stay in uart_tx_feeder.

Test Plan:
- Reset then idle → empty=1, count=0, tx_start=0, tx_data=00; assert rst mid-BUSY → count=0 and tx_start=0 within the same cycle.
- Write 0x41 with a serializer model idle → tx_data=0x41 at N+1, tx_start=1 at N+2; model drops status → pop, count=0, tx_start=0.
- Burst-write 0x31..0x35 → exactly 5 frames emitted in order. Each tx_start rises only after status has returned to 1, and tx_data is stable from LOAD until status falls.
- Write 17 bytes into DEPTH=16 while the serializer is held busy → full=1, count=16, err_overflow=1, 17th byte never transmitted; clr_err → flag 0.
- Serializer model never drops status with TIMEOUT=20 → tx_start high for exactly 20 cycles, then err_timeout=1, byte popped, next byte offered.
- Write and pop in the same cycle at count=3 → count stays 3; pointer wrap after 40 bytes → data order preserved.
